// File: rtl/ac_motor_sine_vector_time.sv
// ---------------------------------------------------------------------------
// ac_motor_sine_vector_time
//
// Space-vector PWM timing generator. A 22-bit phase accumulator spans one
// 60 degree sector and advances by `frequency` every clock. A carry out of the
// accumulator moves to the next sector (0..5, wrapping). The upper ten
// accumulator bits address a sine ROM that covers one sector. The two
// in-sector sine terms are scaled by `u_str` to give the active-vector dwell
// times t1/t2. The remainder of the 16384-count PWM period is split into the
// zero-vector times t0/t7.
//
// Pipeline:
//   stage 0 : acc, internal sector
//   stage 1 : sector, sine_pos, sine_neg          (mutually aligned)
//   stage 2 : u_str * sine_neg, u_str * sine_pos  (u_str sampled here)
//   stage 3 : t0, t1, t2, t7                      (always a consistent set)
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset_n    in   1   asynchronous active-low reset, clears every stage
//   frequency  in  12   angle increment per clock, 0 freezes the angle
//   u_str      in  12   voltage magnitude, 4095 = full scale
//   sector     out  3   current sector 0..5
//   sine_pos   out 12   sine of the angle within the sector
//   sine_neg   out 12   sine of (60 degrees - angle within the sector)
//   t0,t1,t2,t7 out 15  dwell times in PWM counts, summing to 16384
// ---------------------------------------------------------------------------
module ac_motor_sine_vector_time (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] frequency,
    input  logic [11:0] u_str,
    output logic [2:0]  sector,
    output logic [11:0] sine_pos,
    output logic [11:0] sine_neg,
    output logic [14:0] t0,
    output logic [14:0] t1,
    output logic [14:0] t2,
    output logic [14:0] t7
);

    localparam int          ROM_LAST = 1024;
    localparam logic [23:0] TS       = 24'd16384;

    // -----------------------------------------------------------------------
    // Sine ROM contents, evaluated at elaboration time.
    //
    // Entry k = round(4096 * sin(k * pi / 3072)), i.e. the angle k*60/1024
    // degrees on a 2^12 scale. That scale gives the anchor points
    // ROM[0] = 0, ROM[512] = 2048 and ROM[1024] = 3547; the largest entry is
    // 3547, so every entry fits in 12 bits.
    //
    // The sine is a Taylor series up to x^13 in Horner form, evaluated in
    // Q60 fixed point on 128-bit integers. The truncation error is far below
    // one LSB, so the rounding to 12 bits is exact for every entry.
    // -----------------------------------------------------------------------
    function automatic logic [11:0] sine_entry(input int k);
        logic [127:0] one;
        logic [127:0] pi_q60;
        logic [127:0] x;
        logic [127:0] x2;
        logic [127:0] acc_t;
        logic [127:0] s;
        logic [127:0] val;
        one    = 128'd1 << 60;
        pi_q60 = (128'd3141592653589793238 << 60) / 128'd1000000000000000000;
        x      = (128'(k) * pi_q60) / 128'd3072;
        x2     = (x * x) >> 60;
        acc_t  = one;
        // sin x = x(1 - x^2/(2*3)(1 - x^2/(4*5)(1 - ... (1 - x^2/(12*13)))))
        for (int j = 6; j >= 1; j--) begin
            acc_t = one - (((x2 * acc_t) >> 60) / 128'((2 * j) * (2 * j + 1)));
        end
        s   = (x * acc_t) >> 60;
        val = (s * 128'd4096 + (one >> 1)) >> 60;
        return 12'(val);
    endfunction

    // Next sector, wrapping 5 -> 0.
    function automatic logic [2:0] next_sector(input logic [2:0] s);
        return (s == 3'd5) ? 3'd0 : s + 3'd1;
    endfunction

    // Active time: product scaled down by 2^10, truncated.
    function automatic logic [23:0] trunc_shift(input logic [23:0] p);
        return p >> 10;
    endfunction

    // Limit t1 so that t1 + t2 never exceeds the PWM period. t2 is kept as
    // is, and t1 absorbs the overshoot. The active times are not rescaled.
    function automatic logic [23:0] sat_active(input logic [23:0] t_a,
                                               input logic [23:0] t_b);
        return ((t_a + t_b) > TS) ? (TS - t_b) : t_a;
    endfunction

    logic [11:0] sine_rom [0:ROM_LAST];

    genvar g;
    generate
        for (g = 0; g <= ROM_LAST; g++) begin : g_rom
            localparam logic [11:0] ENTRY = sine_entry(g);
            assign sine_rom[g] = ENTRY;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Stage 0: phase accumulator and sector counter
    // -----------------------------------------------------------------------
    logic [21:0] acc_p0;
    logic [2:0]  sector_p0;
    logic [22:0] acc_sum;

    // Bit 22 of the sum is the carry out of the sector-wide accumulator.
    assign acc_sum = {1'b0, acc_p0} + {11'd0, frequency};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_p0    <= '0;
            sector_p0 <= '0;
        end else begin
            acc_p0 <= acc_sum[21:0];
            if (acc_sum[22]) begin
                sector_p0 <= next_sector(sector_p0);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1: sector and sine look-up
    // -----------------------------------------------------------------------
    logic [10:0] idx_pos;
    logic [10:0] idx_neg;
    logic [2:0]  sector_p1;
    logic [11:0] sine_pos_p1;
    logic [11:0] sine_neg_p1;

    // idx runs 0..1023, so the mirrored index runs 1024..1 and entry 1024
    // (60 degrees) is reached at the start of the sector.
    assign idx_pos = {1'b0, acc_p0[21:12]};
    assign idx_neg = 11'd1024 - idx_pos;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sector_p1   <= '0;
            sine_pos_p1 <= '0;
            sine_neg_p1 <= '0;
        end else begin
            sector_p1   <= sector_p0;
            sine_pos_p1 <= sine_rom[idx_pos];
            sine_neg_p1 <= sine_rom[idx_neg];
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: voltage scaling
    // -----------------------------------------------------------------------
    logic [23:0] prod_neg_p2;
    logic [23:0] prod_pos_p2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod_neg_p2 <= '0;
            prod_pos_p2 <= '0;
        end else begin
            prod_neg_p2 <= {12'd0, u_str} * {12'd0, sine_neg_p1};
            prod_pos_p2 <= {12'd0, u_str} * {12'd0, sine_pos_p1};
        end
    end

    // -----------------------------------------------------------------------
    // Stage 3: dwell times
    // -----------------------------------------------------------------------
    logic [23:0] t1_w;
    logic [23:0] t2_w;
    logic [23:0] rem_w;
    logic [23:0] t0_w;
    logic [23:0] t7_w;
    logic [14:0] t0_p3;
    logic [14:0] t1_p3;
    logic [14:0] t2_p3;
    logic [14:0] t7_p3;

    // The zero time is split with t7 taking the odd count, so
    // t0 <= t7 <= t0 + 1 and the four times always sum to the period.
    always_comb begin
        t1_w  = '0;
        t2_w  = '0;
        rem_w = '0;
        t0_w  = '0;
        t7_w  = '0;
        t2_w  = trunc_shift(prod_pos_p2);
        t1_w  = sat_active(trunc_shift(prod_neg_p2), t2_w);
        rem_w = TS - (t1_w + t2_w);
        t0_w  = rem_w >> 1;
        t7_w  = rem_w - t0_w;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t0_p3 <= 15'd8192;
            t1_p3 <= '0;
            t2_p3 <= '0;
            t7_p3 <= 15'd8192;
        end else begin
            t0_p3 <= 15'(t0_w);
            t1_p3 <= 15'(t1_w);
            t2_p3 <= 15'(t2_w);
            t7_p3 <= 15'(t7_w);
        end
    end

    assign sector   = sector_p1;
    assign sine_pos = sine_pos_p1;
    assign sine_neg = sine_neg_p1;
    assign t0       = t0_p3;
    assign t1       = t1_p3;
    assign t2       = t2_p3;
    assign t7       = t7_p3;

endmodule

// File: tb/tb_ac_motor_sine_vector_time.sv
// ---------------------------------------------------------------------------
// Testbench for ac_motor_sine_vector_time.
// The reference model tracks the total electrical angle as an unbounded
// integer per clock edge. It derives the sector, the sines (from $sin) and
// the dwell times from that angle using plain arithmetic.
// ---------------------------------------------------------------------------
module tb_ac_motor_sine_vector_time;

    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] frequency;
    logic [11:0] u_str;
    logic [2:0]  sector;
    logic [11:0] sine_pos;
    logic [11:0] sine_neg;
    logic [14:0] t0;
    logic [14:0] t1;
    logic [14:0] t2;
    logic [14:0] t7;

    always #5 clk = ~clk;

    ac_motor_sine_vector_time dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .frequency(frequency),
        .u_str    (u_str),
        .sector   (sector),
        .sine_pos (sine_pos),
        .sine_neg (sine_neg),
        .t0       (t0),
        .t1       (t1),
        .t2       (t2),
        .t7       (t7)
    );

    int n_vec = 0;
    int n_err = 0;

    // ph_q[n] = total angle after edge n since reset release (ph_q[0] = 0).
    // uq[m]   = u_str sampled at edge m+1.
    longint ph_q[$];
    int     uq[$];
    int     n_edge;

    typedef struct {
        int sec;
        int sp;
        int sn;
        int t0;
        int t1;
        int t2;
        int t7;
    } exp_t;

    function automatic int lut(int k);
        real v;
        v = 4096.0 * $sin(PI * real'(k) / 3072.0);
        return int'($floor(v + 0.5));
    endfunction

    // Expected outputs after the most recent edge.
    function automatic exp_t model_now();
        exp_t   e;
        longint p;
        int     idx, u, a1, a2, r;
        e.sec = 0; e.sp = 0; e.sn = 0;
        e.t0 = 8192; e.t1 = 0; e.t2 = 0; e.t7 = 8192;
        if (n_edge >= 1) begin
            p     = ph_q[n_edge - 1];
            e.sec = int'((p >> 22) % 6);
            idx   = int'((p >> 12) % 1024);
            e.sp  = lut(idx);
            e.sn  = lut(1024 - idx);
        end
        if (n_edge >= 3) begin
            p   = ph_q[n_edge - 3];
            u   = uq[n_edge - 2];
            idx = int'((p >> 12) % 1024);
            a1  = (u * lut(1024 - idx)) / 1024;
            a2  = (u * lut(idx)) / 1024;
            if (a1 + a2 > 16384) a1 = 16384 - a2;
            r    = 16384 - a1 - a2;
            e.t1 = a1;
            e.t2 = a2;
            e.t0 = r / 2;
            e.t7 = r - e.t0;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        uq.push_back(int'(u_str));
        ph_q.push_back(ph_q[n_edge] + longint'(frequency));
        n_edge++;
        #1;
    endtask

    task automatic start_reset();
        reset_n = 1'b0;
        ph_q.delete();
        ph_q.push_back(0);
        uq.delete();
        n_edge = 0;
        #2;
    endtask

    task automatic end_reset();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        reset_n   = 1'b1;
        frequency = '0;
        u_str     = '0;
        #1;
        start_reset();
        end_reset();
        for (int i = 0; i < 60; i++) begin
            frequency = 12'($urandom_range(4095));
            u_str     = 12'($urandom_range(4095));
            tick();
            e = model_now();
            n_vec++;
            if (sector !== 3'(e.sec) || sine_pos !== 12'(e.sp) || sine_neg !== 12'(e.sn) ||
                t0 !== 15'(e.t0) || t1 !== 15'(e.t1) || t2 !== 15'(e.t2) || t7 !== 15'(e.t7)) begin
                n_err++;
                $display("FAIL pre_reset_run @%0d: got sec=%0d sp=%0d sn=%0d t=%0d/%0d/%0d/%0d want sec=%0d sp=%0d sn=%0d t=%0d/%0d/%0d/%0d",
                         n_edge, sector, sine_pos, sine_neg, t0, t1, t2, t7,
                         e.sec, e.sp, e.sn, e.t0, e.t1, e.t2, e.t7);
            end
        end
        // Mid-run reset: every stage clears without waiting for a clock edge.
        start_reset();
        n_vec++;
        if (sector !== 3'd0 || sine_pos !== 12'd0 || sine_neg !== 12'd0) begin
            n_err++;
            $display("FAIL reset_stage1: got sec=%0d sp=%0d sn=%0d want 0/0/0", sector, sine_pos, sine_neg);
        end
        n_vec++;
        if (t0 !== 15'd8192 || t1 !== 15'd0 || t2 !== 15'd0 || t7 !== 15'd8192) begin
            n_err++;
            $display("FAIL reset_times: got t=%0d/%0d/%0d/%0d want 8192/0/0/8192", t0, t1, t2, t7);
        end
        frequency = '0;
        u_str     = 12'd4095;
        end_reset();
        tick();
        n_vec++;
        if (sine_neg !== 12'd3547 || sine_pos !== 12'd0 || sector !== 3'd0) begin
            n_err++;
            $display("FAIL reset_edge1_sine: got sec=%0d sp=%0d sn=%0d want 0/0/3547", sector, sine_pos, sine_neg);
        end
        n_vec++;
        if (t0 !== 15'd8192 || t1 !== 15'd0 || t2 !== 15'd0 || t7 !== 15'd8192) begin
            n_err++;
            $display("FAIL reset_edge1_times: got t=%0d/%0d/%0d/%0d want 8192/0/0/8192", t0, t1, t2, t7);
        end
        tick();
        n_vec++;
        if (t0 !== 15'd8192 || t1 !== 15'd0 || t2 !== 15'd0 || t7 !== 15'd8192) begin
            n_err++;
            $display("FAIL reset_edge2_times: got t=%0d/%0d/%0d/%0d want 8192/0/0/8192", t0, t1, t2, t7);
        end
        tick();
        n_vec++;
        if (t0 !== 15'd1100 || t1 !== 15'd14184 || t2 !== 15'd0 || t7 !== 15'd1100) begin
            n_err++;
            $display("FAIL reset_edge3_times: got t=%0d/%0d/%0d/%0d want 1100/14184/0/1100", t0, t1, t2, t7);
        end
    endtask

    task automatic test_zero_magnitude();
        u_str = '0;
        for (int i = 0; i < 200; i++) begin
            frequency = 12'($urandom_range(4095));
            tick();
            if (i >= 3) begin
                n_vec++;
                if (t0 !== 15'd8192 || t1 !== 15'd0 || t2 !== 15'd0 || t7 !== 15'd8192) begin
                    n_err++;
                    $display("FAIL zero_mag @%0d: got t=%0d/%0d/%0d/%0d want 8192/0/0/8192", i, t0, t1, t2, t7);
                end
            end
        end
    endtask

    task automatic test_mid_sector();
        exp_t e;
        start_reset();
        frequency = 12'd2048;
        u_str     = 12'd4095;
        end_reset();
        // 1024 steps of 2048 put the angle exactly at 512 * 4096.
        for (int i = 0; i < 1024; i++) begin
            tick();
            e = model_now();
            n_vec++;
            if (sector !== 3'(e.sec) || sine_pos !== 12'(e.sp) || sine_neg !== 12'(e.sn) ||
                t0 !== 15'(e.t0) || t1 !== 15'(e.t1) || t2 !== 15'(e.t2) || t7 !== 15'(e.t7)) begin
                n_err++;
                $display("FAIL mid_ramp @%0d: got sec=%0d sp=%0d sn=%0d t=%0d/%0d/%0d/%0d want sec=%0d sp=%0d sn=%0d t=%0d/%0d/%0d/%0d",
                         n_edge, sector, sine_pos, sine_neg, t0, t1, t2, t7,
                         e.sec, e.sp, e.sn, e.t0, e.t1, e.t2, e.t7);
            end
        end
        frequency = '0;
        repeat (4) tick();
        n_vec++;
        if (sine_pos !== 12'd2048 || sine_neg !== 12'd2048) begin
            n_err++;
            $display("FAIL mid_sine: got sp=%0d sn=%0d want 2048/2048", sine_pos, sine_neg);
        end
        n_vec++;
        if (t0 !== 15'd2 || t1 !== 15'd8190 || t2 !== 15'd8190 || t7 !== 15'd2) begin
            n_err++;
            $display("FAIL mid_times: got t=%0d/%0d/%0d/%0d want 2/8190/8190/2", t0, t1, t2, t7);
        end
    endtask

    task automatic test_sector_rotation();
        exp_t e;
        int   changes, last_change, prev_sec, prev_sp, prev_sn, gap;
        start_reset();
        frequency = 12'd4095;
        u_str     = 12'($urandom_range(4095));
        end_reset();
        changes     = 0;
        last_change = 0;
        prev_sec    = 0;
        prev_sp     = 0;
        prev_sn     = 3547;
        for (int i = 0; i < 7000 && changes < 6; i++) begin
            tick();
            e = model_now();
            n_vec++;
            if (sector !== 3'(e.sec) || sine_pos !== 12'(e.sp) || sine_neg !== 12'(e.sn) ||
                t0 !== 15'(e.t0) || t1 !== 15'(e.t1) || t2 !== 15'(e.t2) || t7 !== 15'(e.t7)) begin
                n_err++;
                $display("FAIL rot_model @%0d: got sec=%0d sp=%0d sn=%0d t=%0d/%0d/%0d/%0d want sec=%0d sp=%0d sn=%0d t=%0d/%0d/%0d/%0d",
                         n_edge, sector, sine_pos, sine_neg, t0, t1, t2, t7,
                         e.sec, e.sp, e.sn, e.t0, e.t1, e.t2, e.t7);
            end
            if (n_edge >= 2 && int'(sector) != prev_sec) begin
                n_vec++;
                if (int'(sector) != (prev_sec + 1) % 6) begin
                    n_err++;
                    $display("FAIL rot_order @%0d: got %0d want %0d", n_edge, sector, (prev_sec + 1) % 6);
                end
                gap = n_edge - last_change;
                n_vec++;
                // First carry happens at edge 1025; sector shows it one edge later.
                if (changes == 0 ? (n_edge != 1026) : (gap != 1024 && gap != 1025)) begin
                    n_err++;
                    $display("FAIL rot_interval @%0d: got gap %0d want 1024/1025 (first at edge 1026)", n_edge, gap);
                end
                changes++;
                last_change = n_edge;
            end else if (n_edge >= 2) begin
                n_vec++;
                if (int'(sine_pos) < prev_sp || int'(sine_neg) > prev_sn) begin
                    n_err++;
                    $display("FAIL rot_monotonic @%0d: got sp=%0d sn=%0d after sp=%0d sn=%0d", n_edge,
                             sine_pos, sine_neg, prev_sp, prev_sn);
                end
            end
            prev_sec = int'(sector);
            prev_sp  = int'(sine_pos);
            prev_sn  = int'(sine_neg);
        end
        n_vec++;
        if (changes != 6 || sector !== 3'd0) begin
            n_err++;
            $display("FAIL rot_complete: got %0d changes ending in sector %0d want 6 ending in 0", changes, sector);
        end
    endtask

    task automatic test_latency();
        exp_t e;
        int   change_at;
        start_reset();
        frequency = '0;
        u_str     = '0;
        end_reset();
        repeat (4) tick();
        u_str     = 12'd4095;
        change_at = -1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            e = model_now();
            n_vec++;
            if (t0 !== 15'(e.t0) || t1 !== 15'(e.t1) || t2 !== 15'(e.t2) || t7 !== 15'(e.t7)) begin
                n_err++;
                $display("FAIL latency_model edge+%0d: got t=%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                         i, t0, t1, t2, t7, e.t0, e.t1, e.t2, e.t7);
            end
            n_vec++;
            if (!((t1 === 15'd0 && t0 === 15'd8192 && t7 === 15'd8192) ||
                  (t1 === 15'd14184 && t0 === 15'd1100 && t7 === 15'd1100))) begin
                n_err++;
                $display("FAIL latency_intermediate edge+%0d: got t=%0d/%0d/%0d/%0d", i, t0, t1, t2, t7);
            end
            if (change_at < 0 && t1 !== 15'd0) change_at = i;
        end
        // u_str is sampled into the product at the first edge and the times
        // follow at the next one.
        n_vec++;
        if (change_at != 2) begin
            n_err++;
            $display("FAIL latency_edge: got change after edge +%0d want +2", change_at);
        end
    endtask

    task automatic test_invariant();
        exp_t e;
        int   sum;
        start_reset();
        frequency = 12'($urandom_range(4095));
        u_str     = 12'($urandom_range(4095));
        end_reset();
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(15) == 0) frequency = ($urandom_range(7) == 0) ? 12'd0 : 12'($urandom_range(4095));
            if ($urandom_range(3) == 0) u_str = 12'($urandom_range(4095));
            tick();
            e = model_now();
            n_vec++;
            if (sector !== 3'(e.sec) || sine_pos !== 12'(e.sp) || sine_neg !== 12'(e.sn) ||
                t0 !== 15'(e.t0) || t1 !== 15'(e.t1) || t2 !== 15'(e.t2) || t7 !== 15'(e.t7)) begin
                n_err++;
                $display("FAIL inv_model @%0d: got sec=%0d sp=%0d sn=%0d t=%0d/%0d/%0d/%0d want sec=%0d sp=%0d sn=%0d t=%0d/%0d/%0d/%0d",
                         n_edge, sector, sine_pos, sine_neg, t0, t1, t2, t7,
                         e.sec, e.sp, e.sn, e.t0, e.t1, e.t2, e.t7);
            end
            sum = int'(t0) + int'(t1) + int'(t2) + int'(t7);
            n_vec++;
            if (sum != 16384) begin
                n_err++;
                $display("FAIL inv_sum @%0d: got %0d want 16384", n_edge, sum);
            end
            n_vec++;
            if (!(t0 <= t7 && int'(t7) <= int'(t0) + 1) || sector > 3'd5) begin
                n_err++;
                $display("FAIL inv_order @%0d: got t0=%0d t7=%0d sec=%0d", n_edge, t0, t7, sector);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_magnitude();
        test_mid_sector();
        test_sector_rotation();
        test_latency();
        test_invariant();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
